// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: nibble width, blank
// pattern and the leading-zero test used by scan controllers.
package seg_pkg;

    localparam int         NIBBLE_W   = 4;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         MAX_DIGITS = 8;
    localparam int         WORD_W     = NIBBLE_W * MAX_DIGITS;

    // True when digit idx and every more-significant digit are zero; digit 0 never blanks.
    function automatic logic lz_mask(input logic [WORD_W-1:0] word, input logic [2:0] idx);
        logic nonzero;
        nonzero = 1'b0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k >= int'(idx) && word[NIBBLE_W*k +: NIBBLE_W] != '0)
                nonzero = 1'b1;
        end
        return (idx != 3'd0) && !nonzero;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot divider: counts 0..CLK_DIV-1, flags the last count (tick) and the
// first count (guard) of every slot.
module seg_tick_gen #(
    parameter int CLK_DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic guard
);

    localparam int             CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick  = (cnt == CNT_LAST);
    assign guard = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display: snapshots
// the display word per frame and walks one active-low anode at a time.
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 10000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NIBBLE_W*DIGITS-1:0] data_i,
    input  logic                       load_i,
    input  logic                       lz_en_i,
    output logic [NIBBLE_W-1:0]        dec_o,
    output logic [DIGITS-1:0]          an_o,
    output logic                       blank_o,
    output logic                       frame_o
);

    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int            DW       = NIBBLE_W * DIGITS;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic              tick;
    logic              guard;
    logic              wrap;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     shadow;
    logic [DW-1:0]     pend_data;
    logic              pend;
    logic [DIGITS-1:0] an_sel;
    logic [WORD_W-1:0] word_ext;

    seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .guard (guard)
    );

    assign wrap     = tick && (idx == IDX_LAST);
    assign word_ext = WORD_W'(shadow);

    always_comb begin
        an_sel      = '1;
        an_sel[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Shadow only changes on the frame wrap; a load in the wrap cycle itself bypasses pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data <= '0;
            pend      <= 1'b0;
            shadow    <= '0;
        end else if (wrap) begin
            shadow <= load_i ? data_i : (pend ? pend_data : shadow);
            pend   <= 1'b0;
            if (load_i)
                pend_data <= data_i;
        end else if (load_i) begin
            pend_data <= data_i;
            pend      <= 1'b1;
        end
    end

    // Guard slot keeps all anodes off so the previous digit cannot ghost into the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_o   <= '0;
            an_o    <= '1;
            blank_o <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            dec_o   <= shadow[NIBBLE_W*idx +: NIBBLE_W];
            an_o    <= guard ? '1 : an_sel;
            blank_o <= guard || (lz_en_i && lz_mask(word_ext, 3'(idx)));
            frame_o <= guard && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: a 4-digit/4-clock scanner and an 8-digit/2-clock scanner run
// side by side from a common clock and reset; both have a 16-cycle frame.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic        load;
    logic        lz_en;
    logic [3:0]  dec;
    logic [3:0]  an;
    logic        blank;
    logic        frame;

    logic [31:0] data_b;
    logic [3:0]  dec_b;
    logic [7:0]  an_b;
    logic        blank_b;
    logic        frame_b;

    int checks   = 0;
    int failures = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data),
        .load_i  (load),
        .lz_en_i (lz_en),
        .dec_o   (dec),
        .an_o    (an),
        .blank_o (blank),
        .frame_o (frame)
    );

    seg_scan_ctrl #(.DIGITS(8), .CLK_DIV(2)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_b),
        .load_i  (load),
        .lz_en_i (1'b0),
        .dec_o   (dec_b),
        .an_o    (an_b),
        .blank_o (blank_b),
        .frame_o (frame_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One 16-cycle frame; the load slots are frame cycles whose edge samples load=1.
    task automatic scan_frame(input int fnum, input logic [15:0] word_a, input logic [3:0] bmask,
                              input logic [31:0] word_b, input int sa, input logic [15:0] wa,
                              input int sb, input logic [15:0] wb);
        int         ia;
        int         ib;
        logic       ga;
        logic       gb;
        logic [3:0] ea;
        logic [7:0] eb;
        for (int s = 0; s < 16; s++) begin
            if (s == sa) begin
                data = wa;
                load = 1'b1;
            end else if (s == sb) begin
                data = wb;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            #1;
            ia = s / 4;
            ga = (s % 4) == 0;
            ea = ga ? 4'hF : an_tab[ia];
            check_eq($sformatf("an f%0d s%0d", fnum, s), an, ea);
            check_eq($sformatf("dec f%0d s%0d", fnum, s), dec, word_a[4*ia +: 4]);
            check_eq($sformatf("blank f%0d s%0d", fnum, s), blank, ga || bmask[ia]);
            check_eq($sformatf("frame f%0d s%0d", fnum, s), frame, s == 0);
            ib = s / 2;
            gb = (s % 2) == 0;
            eb = 8'h01 << ib;
            eb = gb ? 8'hFF : ~eb;
            check_eq($sformatf("an_b f%0d s%0d", fnum, s), an_b, eb);
            check_eq($sformatf("dec_b f%0d s%0d", fnum, s), dec_b, word_b[4*ib +: 4]);
            check_eq($sformatf("blank_b f%0d s%0d", fnum, s), blank_b, gb);
            check_eq($sformatf("frame_b f%0d s%0d", fnum, s), frame_b, s == 0);
            check_eq($sformatf("onelow_b f%0d s%0d", fnum, s), $countones(~an_b) <= 1, 1'b1);
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = '0;
        load   = 1'b0;
        lz_en  = 1'b0;
        data_b = 32'h8765_4321;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst an", an, 4'hF);
        check_eq("rst blank", blank, 1'b1);
        check_eq("rst dec", dec, 4'h0);
        check_eq("rst frame", frame, 1'b0);
        rst_n = 1'b1;

        scan_frame(0, 16'h0000, 4'b0000, 32'h0, 2, 16'h1234, -1, 16'h0);
        scan_frame(1, 16'h1234, 4'b0000, 32'h8765_4321, 3, 16'hAAAA, -1, 16'h0);
        scan_frame(2, 16'hAAAA, 4'b0000, 32'h8765_4321, 9, 16'h5555, -1, 16'h0);
        scan_frame(3, 16'h5555, 4'b0000, 32'h8765_4321, 15, 16'h0070, -1, 16'h0);
        lz_en = 1'b1;
        scan_frame(4, 16'h0070, 4'b1100, 32'h8765_4321, 4, 16'h9999, 15, 16'h0000);
        scan_frame(5, 16'h0000, 4'b1110, 32'h8765_4321, -1, 16'h0, -1, 16'h0);
        lz_en = 1'b0;
        scan_frame(6, 16'h0000, 4'b0000, 32'h8765_4321, -1, 16'h0, -1, 16'h0);

        data = 16'h8888;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst an", an, 4'hF);
        check_eq("midrst blank", blank, 1'b1);
        check_eq("midrst dec", dec, 4'h0);
        check_eq("midrst frame", frame, 1'b0);
        check_eq("midrst an_b", an_b, 8'hFF);
        check_eq("midrst blank_b", blank_b, 1'b1);
        check_eq("midrst dec_b", dec_b, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        scan_frame(7, 16'h0000, 4'b0000, 32'h0, -1, 16'h0, -1, 16'h0);
        scan_frame(8, 16'h0000, 4'b0000, 32'h0, -1, 16'h0, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
